// File: rtl/expr_chk_multi.sv
// Multi-channel runtime expression checker: ALWAYS / NEVER / WITHIN modes,
// with per-channel error pulse, sticky flag, saturating count and first-error capture.
module expr_chk_multi #(
   parameter int NCH   = 4,
   parameter int CNT_W = 8,
   parameter int WIN_W = 4,
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [2*NCH-1:0]     mode,
   input  logic [NCH-1:0]       trig,
   input  logic [NCH-1:0]       expr,
   input  logic [WIN_W-1:0]     window,
   input  logic                 clr,
   output logic [NCH-1:0]       err_pulse,
   output logic [NCH-1:0]       err_sticky,
   output logic [NCH*CNT_W-1:0] err_cnt,
   output logic                 first_err_vld,
   output logic [CH_W-1:0]      first_err_ch
);

   localparam logic [1:0] M_ALW = 2'd1;
   localparam logic [1:0] M_NEV = 2'd2;
   localparam logic [1:0] M_WIN = 2'd3;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_ARMED = 1'b1;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NCH-1:0]            state_q, state_d;
   logic [NCH-1:0][WIN_W-1:0] timer_q, timer_d;
   logic [NCH-1:0]            viol;

   logic [NCH-1:0]            pulse_q, pulse_d;
   logic [NCH-1:0]            sticky_q, sticky_d;
   logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic                      fvld_q, fvld_d;
   logic [CH_W-1:0]           fch_q, fch_d;
   logic [CH_W-1:0]           low_idx;

   // Per-channel check evaluation and WITHIN FSM
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      viol    = '0;
      for (int i = 0; i < NCH; i++) begin
         case (mode[2*i +: 2])
            M_ALW: begin
               viol[i]    = en & ~expr[i];
               state_d[i] = S_IDLE;
            end
            M_NEV: begin
               viol[i]    = en & expr[i];
               state_d[i] = S_IDLE;
            end
            M_WIN: begin
               if (en) begin
                  if (state_q[i] == S_IDLE) begin
                     if (trig[i] && !expr[i]) begin
                        if (window == '0) begin
                           viol[i] = 1'b1;
                        end else begin
                           timer_d[i] = window;
                           state_d[i] = S_ARMED;
                        end
                     end
                  end else if (expr[i]) begin
                     state_d[i] = S_IDLE;
                  end else if (timer_q[i] == WIN_W'(1)) begin
                     viol[i]    = 1'b1;
                     state_d[i] = S_IDLE;
                  end else begin
                     timer_d[i] = timer_q[i] - WIN_W'(1);
                  end
               end
            end
            default: begin
               state_d[i] = S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      low_idx = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (viol[i]) begin
            low_idx = CH_W'(i);
         end
      end
   end

   // clr wipes the record first, so a same-cycle violation lands on a clean slate
   always_comb begin
      pulse_d  = viol;
      sticky_d = (clr ? '0 : sticky_q) | viol;
      fvld_d   = clr ? 1'b0 : fvld_q;
      fch_d    = clr ? '0 : fch_q;
      for (int i = 0; i < NCH; i++) begin
         cnt_d[i] = clr ? '0 : cnt_q[i];
         if (viol[i] && (cnt_d[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_d[i] + CNT_W'(1);
         end
      end
      if (!fvld_d && (|viol)) begin
         fvld_d = 1'b1;
         fch_d  = low_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= '0;
         timer_q  <= '0;
         pulse_q  <= '0;
         sticky_q <= '0;
         cnt_q    <= '0;
         fvld_q   <= 1'b0;
         fch_q    <= '0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         pulse_q  <= pulse_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
         fvld_q   <= fvld_d;
         fch_q    <= fch_d;
      end
   end

   assign err_pulse     = pulse_q;
   assign err_sticky    = sticky_q;
   assign err_cnt       = cnt_q;
   assign first_err_vld = fvld_q;
   assign first_err_ch  = fch_q;

endmodule

// File: tb/tb_expr_chk_multi.sv
// Scoreboard bench for expr_chk_multi (NCH=4, CNT_W=2, WIN_W=4):
// directed vectors push expected outputs, a negedge monitor pops and compares.
module tb_expr_chk_multi;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] mode;
   logic [3:0] trig;
   logic [3:0] expr;
   logic [3:0] window;
   logic       clr;
   logic [3:0] err_pulse;
   logic [3:0] err_sticky;
   logic [7:0] err_cnt;
   logic       first_err_vld;
   logic [1:0] first_err_ch;

   typedef struct {
      logic [3:0] p;
      logic [3:0] s;
      logic [7:0] c;
      logic       v;
      logic [1:0] ch;
   } exp_t;

   exp_t q[$];
   int   checks;
   int   errors;

   expr_chk_multi #(
      .NCH   (4),
      .CNT_W (2),
      .WIN_W (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .mode          (mode),
      .trig          (trig),
      .expr          (expr),
      .window        (window),
      .clr           (clr),
      .err_pulse     (err_pulse),
      .err_sticky    (err_sticky),
      .err_cnt       (err_cnt),
      .first_err_vld (first_err_vld),
      .first_err_ch  (first_err_ch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("err_pulse", {4'b0, err_pulse}, {4'b0, e.p});
         chk("err_sticky", {4'b0, err_sticky}, {4'b0, e.s});
         chk("err_cnt", err_cnt, e.c);
         chk("first_err_vld", {7'b0, first_err_vld}, {7'b0, e.v});
         chk("first_err_ch", {6'b0, first_err_ch}, {6'b0, e.ch});
      end
   end

   task automatic set(input logic r, input logic e, input logic c,
                      input logic [7:0] m, input logic [3:0] tg,
                      input logic [3:0] ex, input logic [3:0] w);
      rst    = r;
      en     = e;
      clr    = c;
      mode   = m;
      trig   = tg;
      expr   = ex;
      window = w;
   endtask

   task automatic step(input logic [3:0] p, input logic [3:0] s,
                       input logic [7:0] c, input logic v,
                       input logic [1:0] ch);
      exp_t e;
      e = '{p: p, s: s, c: c, v: v, ch: ch};
      @(posedge clk);
      q.push_back(e);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      checks = 0;
      errors = 0;

      // reset and idle with all channels OFF
      set(1, 0, 0, 8'h00, 4'h0, 4'h0, 4'd0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      rst = 0;
      en  = 1;
      for (int i = 0; i < 20; i++) begin
         expr = 4'($urandom);
         trig = 4'($urandom);
         step(0, 0, 0, 0, 0);
      end

      // ch0 ALWAYS, ch1 NEVER
      set(0, 1, 0, 8'h09, 4'h0, 4'b0001, 4'd0);
      repeat (4) step(0, 0, 0, 0, 0);
      expr = 4'b0010;
      step(4'b0011, 4'b0011, 8'h05, 1, 0);
      expr = 4'b0011;
      step(4'b0010, 4'b0011, 8'h09, 1, 0);
      expr = 4'b0001;
      step(4'b0000, 4'b0011, 8'h09, 1, 0);
      clr = 1;
      step(0, 0, 0, 0, 0);
      clr = 0;

      // ch2 WITHIN window=3, response on last allowed cycle
      set(0, 1, 0, 8'h30, 4'b0100, 4'b0000, 4'd3);
      step(0, 0, 0, 0, 0);
      trig = 4'b0000;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      expr = 4'b0100;
      step(0, 0, 0, 0, 0);
      // no response: error after t+3
      trig = 4'b0100;
      expr = 4'b0000;
      step(0, 0, 0, 0, 0);
      trig = 4'b0000;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(4'b0100, 4'b0100, 8'h10, 1, 2);
      step(4'b0000, 4'b0100, 8'h10, 1, 2);
      // window=0 fails on the trigger cycle
      window = 4'd0;
      trig   = 4'b0100;
      step(4'b0100, 4'b0100, 8'h20, 1, 2);
      trig = 4'b0000;
      step(4'b0000, 4'b0100, 8'h20, 1, 2);
      trig = 4'b0100;
      expr = 4'b0100;
      step(4'b0000, 4'b0100, 8'h20, 1, 2);
      trig = 4'b0000;
      expr = 4'b0000;
      clr  = 1;
      step(0, 0, 0, 0, 0);
      clr = 0;

      // freeze while en=0
      window = 4'd2;
      trig   = 4'b0100;
      step(0, 0, 0, 0, 0);
      trig = 4'b0000;
      en   = 0;
      repeat (5) step(0, 0, 0, 0, 0);
      en = 1;
      step(0, 0, 0, 0, 0);
      step(4'b0100, 4'b0100, 8'h10, 1, 2);
      clr = 1;
      step(0, 0, 0, 0, 0);
      clr = 0;

      // trig while ARMED does not reload
      trig = 4'b0100;
      step(0, 0, 0, 0, 0);
      window = 4'd3;
      step(0, 0, 0, 0, 0);
      trig = 4'b0000;
      step(4'b0100, 4'b0100, 8'h10, 1, 2);
      step(4'b0000, 4'b0100, 8'h10, 1, 2);
      clr = 1;
      step(0, 0, 0, 0, 0);
      clr = 0;

      // mode leaving WITHIN while ARMED drops to IDLE silently
      window = 4'd2;
      trig   = 4'b0100;
      step(0, 0, 0, 0, 0);
      trig = 4'b0000;
      mode = 8'h00;
      step(0, 0, 0, 0, 0);
      mode = 8'h30;
      repeat (3) step(0, 0, 0, 0, 0);

      // saturation at 3 with CNT_W=2
      set(0, 1, 0, 8'h01, 4'h0, 4'b0000, 4'd0);
      step(4'b0001, 4'b0001, 8'h01, 1, 0);
      step(4'b0001, 4'b0001, 8'h02, 1, 0);
      repeat (4) step(4'b0001, 4'b0001, 8'h03, 1, 0);
      // clr with simultaneous violations
      clr  = 1;
      mode = 8'h09;
      expr = 4'b0010;
      step(4'b0011, 4'b0011, 8'h05, 1, 0);
      clr  = 0;
      expr = 4'b0001;
      step(4'b0000, 4'b0011, 8'h05, 1, 0);
      clr  = 1;
      expr = 4'b0011;
      step(4'b0010, 4'b0010, 8'h04, 1, 1);
      expr = 4'b0001;
      step(0, 0, 0, 0, 0);
      clr = 0;

      // reset mid-window
      set(0, 1, 0, 8'hC1, 4'b1000, 4'b0000, 4'd2);
      step(4'b0001, 4'b0001, 8'h01, 1, 0);
      rst  = 1;
      trig = 4'b0000;
      step(0, 0, 0, 0, 0);
      rst  = 0;
      mode = 8'hC0;
      repeat (3) step(0, 0, 0, 0, 0);

      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0",
                  q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/expr_chk_multi.md
Name: expr_chk_multi

Overview:
- Parametrised, multi-channel successor to the single-expression runtime checker used in regression benches.
- Monitors NCH independent 1-bit expressions. Each channel has a run-time selectable mode: must-be-high, must-be-low, or must-go-high within a window after a trigger.
- Per-channel outputs: error pulse, sticky flag and saturating error counter.
- Also captures the first failing channel, so a testbench can $stop or report on any output.

Parameters:
- NCH, 4, number of monitored channels (1..32).
- CNT_W, 8, width of each per-channel saturating error counter.
- WIN_W, 4, width of the response-window value.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  global check enable. While low, no checks run and WITHIN timers freeze.
- mode  input  2*NCH  per-channel mode, channel i at [2i+1:2i]. 0 = OFF, 1 = ALWAYS (expr must be 1), 2 = NEVER (expr must be 0), 3 = WITHIN.
- trig  input  NCH  WITHIN-mode trigger, one bit per channel.
- expr  input  NCH  monitored expressions.
- window  input  WIN_W  WITHIN response window in cycles; shared by all channels; sampled at trigger.
- clr  input  1  clears counters, sticky flags and first-error capture.
- err_pulse  output  NCH  one-cycle pulse per detected violation.
- err_sticky  output  NCH  set on violation; cleared only by rst or clr.
- err_cnt  output  NCH*CNT_W  per-channel error count, channel i at [CNT_W*(i+1)-1:CNT_W*i].
- first_err_vld  output  1  a first error has been captured.
- first_err_ch  output  max(1,$clog2(NCH))  index of the first failing channel.

Behaviour:
- Reset (rst=1 at posedge): every output 0, all channels IDLE, all timers 0.
- Latency: a violation evaluated at cycle t appears on err_pulse, err_sticky, err_cnt and first_err_* after the posedge ending cycle t (one register stage). Nothing is combinational from inputs to outputs.
- OFF mode: never flags; channel state forced to IDLE.
- ALWAYS mode: violation in any cycle with en=1 and expr=0.
- NEVER mode: violation in any cycle with en=1 and expr=1.
- WITHIN mode, per-channel FSM with states IDLE and ARMED, plus a WIN_W-bit timer:
  - IDLE, en=1, trig=1, expr=1: pass; stay IDLE.
  - IDLE, en=1, trig=1, expr=0, window=0: violation; stay IDLE.
  - IDLE, en=1, trig=1, expr=0, window>0: timer <= window; go ARMED.
  - ARMED, en=1, expr=1: go IDLE, no error.
  - ARMED, en=1, expr=0, timer==1: violation; go IDLE.
  - ARMED, en=1, expr=0, timer>1: timer <= timer-1.
  - Net effect: expr is accepted on the trigger cycle or any of the following `window` cycles.
  - trig while ARMED is ignored: no re-arm, no timer reload.
  - en=0: state and timer hold.
  - mode changed away from 3 while ARMED: go IDLE next cycle, no error.
- Counters saturate at 2^CNT_W-1; further violations still pulse err_pulse.
- first_err: captured on the first violation after rst or clr. If several channels fail in the same cycle, the lowest index wins. Held until rst or clr.
- clr and a violation in the same cycle: clear applies first, then the violation is recorded. Result: count=1, sticky=1, first_err reloaded with this cycle's failing channel.
- clr does not affect FSM state or timers.
- rst takes precedence over everything, including an ARMED channel mid-window: it returns IDLE with no error.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, mode=all OFF, toggle expr randomly for 20 cycles -> all outputs remain 0.
- ALWAYS/NEVER: ch0 ALWAYS, ch1 NEVER, en=1. Drive expr[0]=0 at cycle 5 and expr[1]=1 at cycles 5,6. Expected after each of those cycles:
  - err_pulse[0] high for 1 cycle; err_pulse[1] high for 2 cycles.
  - err_cnt ch0=1, ch1=2.
  - first_err_ch=0 (lowest index wins at cycle 5).
- WITHIN window: ch2 WITHIN, window=3, trig at t.
  - expr high at t+3 -> no error.
  - Repeat with expr never high -> err_pulse[2] asserted exactly after cycle t+3.
  - window=0, trig with expr=0 -> error after cycle t.
- Freeze/re-trigger: ch2 ARMED with window=2; en=0 for 5 cycles; then en=1, expr=0 -> error after the 2nd enabled cycle. A trig during ARMED does not extend the deadline.
- Saturation and clr: CNT_W=2, ch0 ALWAYS, expr[0]=0 for 6 cycles -> err_cnt ch0 stops at 3 while err_pulse stays high. clr with a simultaneous violation -> err_cnt=1, err_sticky=1, first_err_vld=1.
- Mid-window reset: ch3 ARMED, rst=1 for one cycle with expr=0 past the deadline -> no err_pulse; ch3 IDLE; all outputs 0.
